// File: rtl/lock_pkg.sv
// Shared constants for the keypad code checker: key codes, FSM encoding,
// clock rate and helpers for turning seconds into cycles.
package lock_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  localparam int unsigned CLK_HZ       = 12_000_000;
  localparam int unsigned TIMEOUT_SECS = 5;
  localparam int unsigned UNLOCK_SECS  = 3;
  localparam int unsigned LOCKOUT_SECS = 10;

  function automatic int unsigned secs_to_cycles(input int unsigned secs);
    return secs * CLK_HZ;
  endfunction

  // Mask covering the low 4*len bits of a 32-bit BCD word.
  function automatic logic [31:0] len_mask(input logic [3:0] len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len)) m[4*i +: 4] = 4'hF;
    end
    return m;
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/code_match.sv
// Combinational comparison of the typed entry against every stored code.
// A code matches when the digit count equals its length and the low nibbles
// of the buffer equal the code; any overflow rejects the entry outright.
module code_match
  import lock_pkg::*;
#(
  parameter int unsigned               MAX_DIGITS = 8,
  parameter int unsigned               NUM_CODES  = 2,
  parameter logic [NUM_CODES*32-1:0]   CODES      = {32'h0011_1111, 32'h0000_1111},
  parameter logic [NUM_CODES*4-1:0]    CODE_LENS  = {4'd6, 4'd4}
) (
  input  logic [4*MAX_DIGITS-1:0] digit_buf,
  input  logic [3:0]              digit_count,
  input  logic                    overflow,
  output logic                    match
);

  logic [31:0]          buf_ext;
  logic [NUM_CODES-1:0] hit;

  assign buf_ext = 32'(digit_buf);

  for (genvar i = 0; i < NUM_CODES; i++) begin : g_code
    localparam logic [3:0]  LEN  = CODE_LENS[4*i +: 4];
    localparam logic [31:0] CODE = CODES[32*i +: 32];
    localparam logic [31:0] MASK = len_mask(LEN);
    assign hit[i] = (digit_count == LEN) && ((buf_ext & MASK) == (CODE & MASK));
  end

  assign match = !overflow && (|hit);

endmodule

// File: rtl/code_lock_checker.sv
// Keypad code checker: buffers digit strobes, checks them on ENTER, holds
// the lock open for a while on success and locks the keypad out after too
// many consecutive failures. One shared down-counter times every state.
module code_lock_checker
  import lock_pkg::*;
#(
  parameter int unsigned             MAX_DIGITS     = 8,
  parameter int unsigned             NUM_CODES      = 2,
  parameter logic [NUM_CODES*32-1:0] CODES          = {32'h0011_1111, 32'h0000_1111},
  parameter logic [NUM_CODES*4-1:0]  CODE_LENS      = {4'd6, 4'd4},
  parameter int unsigned             MAX_FAILS      = 3,
  parameter int unsigned             TIMEOUT_CYCLES = secs_to_cycles(TIMEOUT_SECS),
  parameter int unsigned             UNLOCK_CYCLES  = secs_to_cycles(UNLOCK_SECS),
  parameter int unsigned             LOCKOUT_CYCLES = secs_to_cycles(LOCKOUT_SECS)
) (
  input  logic                             hwclk,
  input  logic                             reset,
  input  logic [3:0]                       key,
  input  logic                             key_valid,
  output logic                             unlock,
  output logic                             fail,
  output logic                             locked_out,
  output logic [3:0]                       digit_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int unsigned BUF_W   = 4 * MAX_DIGITS;
  localparam int unsigned FC_W    = $clog2(MAX_FAILS + 1);
  localparam int unsigned MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > MAX_UL) ? TIMEOUT_CYCLES : MAX_UL;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  // Loads are one less than the duration: the counter expires on the edge
  // after it reaches zero, giving exactly N cycles in the state.
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [BUF_W-1:0] digit_buf_q, digit_buf_d;
  logic [3:0]       digit_count_q, digit_count_d;
  logic             overflow_q, overflow_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [FC_W-1:0]  fail_count_q, fail_count_d;
  logic             fail_q, fail_d;
  logic             unlock_q, unlock_d;
  logic             locked_out_q, locked_out_d;
  logic             match;

  code_match #(
    .MAX_DIGITS (MAX_DIGITS),
    .NUM_CODES  (NUM_CODES),
    .CODES      (CODES),
    .CODE_LENS  (CODE_LENS)
  ) u_code_match (
    .digit_buf   (digit_buf_q),
    .digit_count (digit_count_q),
    .overflow    (overflow_q),
    .match       (match)
  );

  // Next-state, buffer, timer and fail-counter logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    digit_buf_d   = digit_buf_q;
    digit_count_d = digit_count_q;
    overflow_d    = overflow_q;
    fail_count_d  = fail_count_q;
    fail_d        = 1'b0;
    timer_d       = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (key_valid && is_digit(key)) begin
          digit_buf_d   = BUF_W'(key);
          digit_count_d = 4'd1;
          state_d       = S_ENTRY;
        end else if (key_valid && key == KEY_ENTER) begin
          state_d = S_CHECK;
        end
      end
      S_ENTRY: begin
        if (key_valid && is_digit(key)) begin
          digit_buf_d = (digit_buf_q << 4) | BUF_W'(key);
          if (digit_count_q == 4'(MAX_DIGITS)) overflow_d    = 1'b1;
          else                                 digit_count_d = digit_count_q + 4'd1;
          timer_d = TIMEOUT_LOAD;
        end else if (key_valid && key == KEY_ENTER) begin
          state_d = S_CHECK;
        end else if ((key_valid && key == KEY_CLEAR) || timer_q == '0) begin
          digit_buf_d   = '0;
          digit_count_d = '0;
          overflow_d    = 1'b0;
          state_d       = S_IDLE;
        end
      end
      S_CHECK: begin
        digit_buf_d   = '0;
        digit_count_d = '0;
        overflow_d    = 1'b0;
        if (match) begin
          fail_count_d = '0;
          state_d      = S_UNLOCKED;
        end else begin
          fail_d       = 1'b1;
          fail_count_d = fail_count_q + FC_W'(1);
          state_d      = (fail_count_d == FC_W'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_UNLOCKED: begin
        if ((key_valid && key == KEY_CLEAR) || timer_q == '0) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_count_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state entry restarts the shared timer with that state's budget.
    if (state_d != state_q) begin
      case (state_d)
        S_ENTRY:    timer_d = TIMEOUT_LOAD;
        S_UNLOCKED: timer_d = UNLOCK_LOAD;
        S_LOCKOUT:  timer_d = LOCKOUT_LOAD;
        default:    timer_d = '0;
      endcase
    end

    unlock_d     = (state_d == S_UNLOCKED);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // State registers with synchronous reset that overrides any activity.
  always_ff @(posedge hwclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      digit_buf_q   <= '0;
      digit_count_q <= '0;
      overflow_q    <= 1'b0;
      timer_q       <= '0;
      fail_count_q  <= '0;
      fail_q        <= 1'b0;
      unlock_q      <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_buf_q   <= digit_buf_d;
      digit_count_q <= digit_count_d;
      overflow_q    <= overflow_d;
      timer_q       <= timer_d;
      fail_count_q  <= fail_count_d;
      fail_q        <= fail_d;
      unlock_q      <= unlock_d;
      locked_out_q  <= locked_out_d;
    end
  end

  assign unlock      = unlock_q;
  assign fail        = fail_q;
  assign locked_out  = locked_out_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_code_lock_checker.sv
// Bench for code_lock_checker: a vector table, directed multi-cycle
// sequences, and a randomized run, all compared against a queue-based model.
module tb_code_lock_checker;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned NUM_CODES  = 2;
  localparam logic [63:0] TB_CODES   = {32'h0011_1111, 32'h0000_1111};
  localparam logic [7:0]  TB_LENS    = {4'd6, 4'd4};
  localparam int unsigned MAX_FAILS  = 3;
  localparam int          T_OUT      = 50;
  localparam int          T_UNL      = 20;
  localparam int          T_LCK      = 40;
  localparam logic [3:0]  K_CLR      = 4'd10;
  localparam logic [3:0]  K_ENT      = 4'd11;

  logic       hwclk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key = '0;
  logic       key_valid = 1'b0;
  logic       unlock, fail, locked_out;
  logic [3:0] digit_count;
  logic [1:0] fail_count;

  int n_pass = 0;
  int n_total = 0;

  code_lock_checker #(
    .MAX_DIGITS     (MAX_DIGITS),
    .NUM_CODES      (NUM_CODES),
    .CODES          (TB_CODES),
    .CODE_LENS      (TB_LENS),
    .MAX_FAILS      (MAX_FAILS),
    .TIMEOUT_CYCLES (T_OUT),
    .UNLOCK_CYCLES  (T_UNL),
    .LOCKOUT_CYCLES (T_LCK)
  ) dut (
    .hwclk       (hwclk),
    .reset       (reset),
    .key         (key),
    .key_valid   (key_valid),
    .unlock      (unlock),
    .fail        (fail),
    .locked_out  (locked_out),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  always #5 hwclk = ~hwclk;

  // ---------------- reference model (behavioural) ----------------
  int m_digits[$];
  bit m_pending;
  int m_unlock_left, m_lock_left, m_idle, m_fails;
  bit m_fail;

  function automatic bit m_match();
    int n;
    n = m_digits.size();
    if (n > int'(MAX_DIGITS)) return 1'b0;
    for (int i = 0; i < int'(NUM_CODES); i++) begin
      int len;
      bit ok;
      len = int'((TB_LENS >> (4*i)) & 8'hF);
      ok  = (n == len);
      for (int j = 0; j < len && ok; j++)
        if (m_digits[n-1-j] != int'((TB_CODES >> (32*i + 4*j)) & 64'hF)) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit kv, input logic [3:0] k);
    m_fail = 1'b0;
    if (r) begin
      m_digits.delete();
      m_pending = 0; m_unlock_left = 0; m_lock_left = 0; m_idle = 0; m_fails = 0;
    end else if (m_pending) begin
      m_pending = 0;
      if (m_match()) begin
        m_unlock_left = T_UNL;
        m_fails = 0;
      end else begin
        m_fail = 1'b1;
        m_fails++;
        if (m_fails == int'(MAX_FAILS)) m_lock_left = T_LCK;
      end
      m_digits.delete();
    end else if (m_unlock_left > 0) begin
      if (kv && k == K_CLR) m_unlock_left = 0;
      else                  m_unlock_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (kv && k <= 4'd9) begin
      m_digits.push_back(int'(k));
      m_idle = 0;
    end else if (kv && k == K_CLR) begin
      m_digits.delete();
    end else if (kv && k == K_ENT) begin
      m_pending = 1;
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == T_OUT) m_digits.delete();
    end
  endtask

  function automatic logic [8:0] model_obs();
    int dc;
    dc = (m_digits.size() > int'(MAX_DIGITS)) ? int'(MAX_DIGITS) : m_digits.size();
    return {m_unlock_left > 0, m_fail, m_lock_left > 0, 4'(dc), 2'(m_fails)};
  endfunction

  function automatic logic [8:0] obs();
    return {unlock, fail, locked_out, digit_count, fail_count};
  endfunction

  // ---------------- checking and driving ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive, take the edge, advance the model, compare 1 ns later.
  task automatic cycle(input bit r, input bit kv, input logic [3:0] k);
    reset = r; key_valid = kv; key = k;
    @(posedge hwclk);
    model_step(r, kv, k);
    #1;
    reset = 1'b0; key_valid = 1'b0; key = '0;
    check("model", 32'(obs()), 32'(model_obs()));
  endtask

  task automatic press(input logic [3:0] k);
    cycle(1'b0, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0);
  endtask

  task automatic type_code(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) press(d);
    press(K_ENT);
  endtask

  typedef struct {
    bit         rst;
    bit         kv;
    logic [3:0] k;
    bit         e_unlock;
    bit         e_fail;
    bit         e_lo;
    logic [3:0] e_dc;
    logic [1:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit kv, input logic [3:0] k, input bit u,
                     input bit f, input bit lo, input logic [3:0] dc, input logic [1:0] fc);
    vec_t v;
    v.rst = r; v.kv = kv; v.k = k; v.e_unlock = u; v.e_fail = f;
    v.e_lo = lo; v.e_dc = dc; v.e_fc = fc;
    vecs.push_back(v);
  endtask

  initial begin
    int n_unl, n_lo, r;
    bit fail_seen, unl_seen;
    logic [3:0] seq_c[7];
    logic [3:0] seq_d[5];

    // rst kv key   unl fail lo dc fc
    add(1, 0, 4'd0,  0, 0, 0, 0, 0);
    add(0, 1, 4'd1,  0, 0, 0, 1, 0);
    add(0, 0, 4'd0,  0, 0, 0, 1, 0);
    add(0, 1, 4'd1,  0, 0, 0, 2, 0);
    add(0, 1, 4'd1,  0, 0, 0, 3, 0);
    add(0, 1, 4'd15, 0, 0, 0, 3, 0);
    add(0, 1, 4'd1,  0, 0, 0, 4, 0);
    add(0, 1, K_ENT, 0, 0, 0, 4, 0);
    add(0, 0, 4'd0,  1, 0, 0, 0, 0);
    add(0, 1, 4'd5,  1, 0, 0, 0, 0);
    add(0, 1, K_CLR, 0, 0, 0, 0, 0);
    add(0, 1, 4'd9,  0, 0, 0, 1, 0);
    add(0, 1, K_ENT, 0, 0, 0, 1, 0);
    add(0, 0, 4'd0,  0, 1, 0, 0, 1);
    add(0, 0, 4'd0,  0, 0, 0, 0, 1);
    add(0, 1, K_CLR, 0, 0, 0, 0, 1);
    add(0, 1, 4'd2,  0, 0, 0, 1, 1);
    add(0, 1, K_CLR, 0, 0, 0, 0, 1);
    add(0, 1, K_ENT, 0, 0, 0, 0, 1);
    add(0, 0, 4'd0,  0, 1, 0, 0, 2);
    add(0, 0, 4'd0,  0, 0, 0, 0, 2);
    add(0, 1, 4'd1,  0, 0, 0, 1, 2);
    add(0, 1, 4'd1,  0, 0, 0, 2, 2);
    add(0, 1, 4'd1,  0, 0, 0, 3, 2);
    add(0, 1, 4'd1,  0, 0, 0, 4, 2);
    add(0, 1, K_ENT, 0, 0, 0, 4, 2);
    add(0, 0, 4'd0,  1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].kv, vecs[i].k);
      check($sformatf("vec%0d", i), 32'(obs()),
            32'({vecs[i].e_unlock, vecs[i].e_fail, vecs[i].e_lo, vecs[i].e_dc, vecs[i].e_fc}));
    end

    // A: 1111# unlocks one edge after ENTER and holds exactly T_UNL cycles.
    cycle(1'b1, 1'b0, 4'd0);
    type_code(4, 4'd1);
    check("A.unlock_before", 32'(unlock), 32'd0);
    n_unl = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (unlock) n_unl++;
      else if (n_unl > 0) break;
    end
    check("A.unlock_len", n_unl, T_UNL);
    check("A.fail_count", 32'(fail_count), 32'd0);

    // B: six ones unlock, five ones fail for one cycle.
    type_code(6, 4'd1);
    idle(1);
    check("B.six_unlock", 32'(unlock), 32'd1);
    press(K_CLR);
    check("B.clear_relock", 32'(unlock), 32'd0);
    type_code(5, 4'd1);
    idle(1);
    check("B.five_fail", 32'({unlock, fail, fail_count}), 32'({1'b0, 1'b1, 2'd1}));
    idle(1);
    check("B.fail_width", 32'(fail), 32'd0);

    // C: nine digits overflow and fail; a cleared mistake then unlocks cleanly.
    type_code(9, 4'd1);
    idle(1);
    check("C.overflow_fail", 32'({fail, fail_count}), 32'({1'b1, 2'd2}));
    seq_c = '{4'd2, K_CLR, 4'd1, 4'd1, 4'd1, 4'd1, K_ENT};
    fail_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      press(seq_c[i]);
      fail_seen |= fail;
    end
    idle(1);
    fail_seen |= fail;
    check("C.no_fail", 32'(fail_seen), 32'd0);
    check("C.unlock", 32'({unlock, fail_count}), 32'({1'b1, 2'd0}));
    press(K_CLR);

    // D: three wrong entries lock out for T_LCK cycles; keys are ignored meanwhile.
    for (int a = 0; a < 3; a++) begin
      press(4'd9);
      press(K_ENT);
      idle(1);
      if (a < 2) check("D.no_lockout_yet", 32'({fail, locked_out}), 32'({1'b1, 1'b0}));
    end
    check("D.third_fail_lockout", 32'({fail, locked_out, fail_count}), 32'({1'b1, 1'b1, 2'd3}));
    seq_d = '{4'd1, 4'd1, 4'd1, 4'd1, K_ENT};
    n_lo = 1;
    unl_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i < 5) press(seq_d[i]);
      else       idle(1);
      unl_seen |= unlock;
      if (locked_out) n_lo++;
      else break;
    end
    check("D.lockout_len", n_lo, T_LCK);
    check("D.ignored_code", 32'(unl_seen), 32'd0);
    check("D.fail_count_cleared", 32'(fail_count), 32'd0);
    type_code(4, 4'd1);
    idle(1);
    check("D.unlock_after", 32'(unlock), 32'd1);
    press(K_CLR);

    // E: inter-key timeout discards the entry on the T_OUT-th idle cycle.
    press(4'd1);
    press(4'd1);
    idle(T_OUT - 1);
    check("E.before_timeout", 32'(digit_count), 32'd2);
    idle(1);
    check("E.timeout", 32'(digit_count), 32'd0);
    type_code(2, 4'd1);
    idle(1);
    check("E.short_fail", 32'({unlock, fail}), 32'({1'b0, 1'b1}));

    // F: reset overrides UNLOCKED and LOCKOUT on the next edge.
    type_code(4, 4'd1);
    idle(3);
    check("F.unlocked", 32'(unlock), 32'd1);
    cycle(1'b1, 1'b0, 4'd0);
    check("F.reset_unlocked", 32'(obs()), 32'd0);
    for (int a = 0; a < 3; a++) begin
      press(4'd9);
      press(K_ENT);
      idle(1);
    end
    idle(5);
    check("F.locked", 32'(locked_out), 32'd1);
    cycle(1'b1, 1'b0, 4'd0);
    check("F.reset_lockout", 32'(obs()), 32'd0);

    // Randomized run, compared cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (n % 500 == 499)   idle(T_OUT + 5);
      else if (r < 50)      idle(1);
      else if (r < 72)      press(4'd1);
      else if (r < 82)      press(K_ENT);
      else if (r < 87)      press(K_CLR);
      else                  press(4'($urandom_range(0, 9)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/code_lock_checker.md
# code_lock_checker

Parametrised keypad code checker. Sits between the keypad digit decoder and the lock outputs: it consumes one-cycle key strobes, buffers up to `MAX_DIGITS` digits, and compares the entry against `NUM_CODES` stored codes when the enter key is pressed. It adds an explicit enter/clear key, variable code length, an inter-key timeout, an unlock hold window, and a failed-attempt lockout.

## Interface

**Parameters**
- `MAX_DIGITS`, default 8: digit buffer depth, 1..8.
- `NUM_CODES`, default 2: number of stored codes, ≥1.
- `CODES`, default `{32'h0011_1111, 32'h0000_1111}`: `NUM_CODES`×32 bits; code *i* is bits [32i+31:32i], BCD, right-aligned; the most recently typed digit is in the lowest nibble.
- `CODE_LENS`, default `{4'd6, 4'd4}`: `NUM_CODES`×4 bits; length of code *i*, 1..`MAX_DIGITS`.
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout, ≥1.
- `TIMEOUT_CYCLES`, default 60_000_000: inter-key idle limit (5 s at 12 MHz).
- `UNLOCK_CYCLES`, default 36_000_000: unlock hold time.
- `LOCKOUT_CYCLES`, default 120_000_000: lockout duration.

**Ports**
- `hwclk` in 1: system clock, 12 MHz.
- `reset` in 1: synchronous, active-high.
- `key` in 4: key code. 0–9 are digits, 10 is CLEAR (`*`), 11 is ENTER (`#`), 12–15 are ignored.
- `key_valid` in 1: one-cycle strobe; `key` is sampled only while it is high.
- `unlock` out 1: high while in UNLOCKED.
- `fail` out 1: one-cycle pulse per rejected attempt.
- `locked_out` out 1: high while in LOCKOUT.
- `digit_count` out 4: number of digits buffered, saturating at `MAX_DIGITS`.
- `fail_count` out 2..: `$clog2(MAX_FAILS+1)` bits; consecutive failures.

## Operation

- **States:** IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT.
- **IDLE**
  - Digit: shift into the buffer, `digit_count`=1, go to ENTRY.
  - ENTER: go to CHECK with an empty entry. This always fails.
  - CLEAR: no effect.
- **ENTRY**
  - Digit: `buf <= {buf, key}` (oldest nibble drops out). `digit_count` increments.
  - A digit arriving while `digit_count == MAX_DIGITS` sets a sticky `overflow` flag.
  - CLEAR: clear the buffer, count and overflow, then go to IDLE. Not counted as a failure.
  - ENTER: go to CHECK.
  - No `key_valid` for `TIMEOUT_CYCLES`: discard the entry, go to IDLE. Not counted as a failure.
- **CHECK** (one cycle)
  - Match: `!overflow` and, for some *i*, `digit_count == CODE_LENS[i]` and the low `4*CODE_LENS[i]` bits of `buf` equal the corresponding bits of code *i*.
  - Match → UNLOCKED, `fail_count` ← 0.
  - No match → pulse `fail`, increment `fail_count`. If the new value equals `MAX_FAILS`, go to LOCKOUT; otherwise go to IDLE.
  - The buffer, count and overflow are cleared on leaving CHECK.
- **UNLOCKED**
  - Hold for `UNLOCK_CYCLES`, then go to IDLE.
  - CLEAR relocks immediately (next cycle IDLE). All other keys are ignored.
- **LOCKOUT**
  - All keys are ignored.
  - After `LOCKOUT_CYCLES`: `fail_count` ← 0, go to IDLE.
- **Single timer:** one down-counter, reloaded on every state entry and on every accepted key in ENTRY. Its width is sized from the largest cycle parameter.
- **Reset:** state=IDLE. All outputs 0, buffer/overflow/timer cleared. Reset asserted mid-operation (including UNLOCKED or LOCKOUT) takes effect on the next edge and overrides everything.

## Timing

- `key_valid` sampled at edge *t*: buffer and `digit_count` update at *t*.
- ENTER at edge *t*: CHECK occupies cycle *t*+1. At edge *t*+1 the state moves to UNLOCKED, or `fail` is registered high.
  - `unlock` or `fail` is visible at *t*+1 (registered output).
  - `fail` lasts exactly one cycle.
- `key_valid` during CHECK is dropped.
- `unlock` is high for exactly `UNLOCK_CYCLES` cycles when not relocked early.
- `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles.
- Timeout fires on the `TIMEOUT_CYCLES`-th idle cycle after the last accepted key.
- If a key strobe and the timeout coincide on the same edge, the key wins and the timer reloads.

## Structure

- **Shared package `lock_pkg`:**
  - Key-code constants `KEY_CLEAR`=10, `KEY_ENTER`=11.
  - State encoding.
  - `CLK_HZ`=12_000_000 and seconds-to-cycles helper constants.
- **One sub-module, `code_match`:** combinational. Takes `buf`, `digit_count`, `overflow`, `CODES`, `CODE_LENS`; returns `match`. It is a generate loop over `NUM_CODES` with a per-code length mask.
- The FSM, timer and fail counter stay in `code_lock_checker`.

## Test plan

Simulation overrides: `TIMEOUT_CYCLES`=50, `UNLOCK_CYCLES`=20, `LOCKOUT_CYCLES`=40.

- Keys 1,1,1,1,ENTER → `unlock` rises one edge after ENTER, stays high exactly 20 cycles; `fail_count`=0.
- Keys 1×6,ENTER → unlock. Keys 1×5,ENTER → `fail` pulse for one cycle, `fail_count`=1, no unlock.
- Keys 1×9,ENTER (overflow) → `fail`. Keys 2,CLEAR,1,1,1,1,ENTER → unlock with no fail counted.
- Three wrong entries (9,ENTER ×3) → third `fail` coincides with `locked_out` going high for 40 cycles. Correct code during lockout is ignored. After lockout, `fail_count`=0 and 1,1,1,1,ENTER unlocks.
- Keys 1,1, then 50 idle cycles → `digit_count` returns to 0, state IDLE; subsequent 1,1,ENTER fails (length 2).
- `reset` pulsed while `unlock`=1 and while `locked_out`=1 → all outputs 0 on the next edge, `fail_count`=0.
